// File: rtl/i2c_target_rx.sv
// i2c_target_rx: write-only I2C target front-end for the I2C-to-SPI bridge.
// Oversamples SCL/SDA, ACKs its address, hands data bytes out on valid/ready.
module i2c_target_rx #(
    parameter logic [6:0]  TARGET_ADDR = 7'h42,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_first,
    output logic       busy,
    output logic       ovf
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_p_q;
    logic                   sda_p_q;
    logic [2:0]             cnt_q;
    logic [7:0]             shift_q;
    logic                   load_q;
    logic                   first_pend_q;
    logic                   sda_oe_q;
    logic [7:0]             rx_data_q;
    logic                   rx_valid_q;
    logic                   rx_first_q;
    logic                   busy_q;
    logic                   ovf_q;

    logic       scl_s;
    logic       sda_s;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic       buf_free;
    logic [7:0] byte_d;
    logic [2:0] cnt_d;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_p_q;
    assign scl_fall  = ~scl_s & scl_p_q;
    assign start_det = scl_s & sda_p_q & ~sda_s;
    assign stop_det  = scl_s & ~sda_p_q & sda_s;
    // Slot is free if empty or being drained in this very cycle
    assign buf_free  = ~rx_valid_q | rx_ready;
    assign byte_d    = {shift_q[6:0], sda_s};
    assign cnt_d     = cnt_q + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            scl_sync_q   <= '1;
            sda_sync_q   <= '1;
            scl_p_q      <= 1'b1;
            sda_p_q      <= 1'b1;
            cnt_q        <= 3'd0;
            shift_q      <= 8'd0;
            load_q       <= 1'b0;
            first_pend_q <= 1'b0;
            sda_oe_q     <= 1'b0;
            rx_data_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            rx_first_q   <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_p_q    <= scl_s;
            sda_p_q    <= sda_s;
            ovf_q      <= 1'b0;
            load_q     <= 1'b0;

            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            if (load_q) begin
                rx_data_q    <= shift_q;
                rx_valid_q   <= 1'b1;
                rx_first_q   <= first_pend_q;
                first_pend_q <= 1'b0;
            end
            if (scl_rise) begin
                shift_q <= byte_d;
            end

            if (start_det) begin
                state_q  <= ADDR;
                busy_q   <= 1'b1;
                sda_oe_q <= 1'b0;
                cnt_q    <= 3'd0;
            end else if (stop_det) begin
                state_q  <= IDLE;
                busy_q   <= 1'b0;
                sda_oe_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ADDR: begin
                        if (scl_rise) begin
                            cnt_q <= cnt_d;
                            if (cnt_q == 3'd7) begin
                                if (byte_d == {TARGET_ADDR, 1'b0}) begin
                                    state_q <= ADDR_ACK;
                                end else begin
                                    state_q <= IGNORE;
                                end
                            end
                        end
                    end
                    ADDR_ACK,
                    DATA_ACK: begin
                        // First fall opens the ACK slot, second fall closes it
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= DATA;
                                if (state_q == ADDR_ACK) begin
                                    first_pend_q <= 1'b1;
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (scl_rise) begin
                            cnt_q <= cnt_d;
                            if (cnt_q == 3'd7) begin
                                if (buf_free) begin
                                    load_q  <= 1'b1;
                                    state_q <= DATA_ACK;
                                end else begin
                                    ovf_q   <= 1'b1;
                                    state_q <= IGNORE;
                                end
                            end
                        end
                    end
                    default: begin
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_first = rx_first_q;
    assign busy     = busy_q;
    assign ovf      = ovf_q;

endmodule

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
- Write-only I2C target front-end feeding the SPI master stage of tt_um_I2C_to_SPI.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches the 7-bit address and ACKs it.
- Delivers each received data byte on a valid/ready interface to the downstream SPI stage.
- Drives SDA low only, through an open-drain enable.

Parameters:
- TARGET_ADDR, 7'h42, 7-bit I2C address this target responds to.
- SYNC_STAGES, 2, synchronizer depth on scl_i/sda_i; legal range 2..3.

Ports:
- clk  input  1  system clock; must be at least 8x the SCL frequency.
- rst_n  input  1  asynchronous active-low reset.
- scl_i  input  1  raw I2C clock from the pad.
- sda_i  input  1  raw I2C data from the pad.
- sda_oe  output  1  1 = pull SDA low (ACK); 0 = release.
- rx_data  output  8  received data byte; stable while rx_valid=1.
- rx_valid  output  1  byte available to the downstream SPI stage.
- rx_ready  input  1  downstream accepts the byte; transfer occurs when rx_valid & rx_ready.
- rx_first  output  1  qualifies rx_data: first data byte after the address phase.
- busy  output  1  1 from START until STOP.
- ovf  output  1  one-cycle pulse when a byte is dropped because the buffer is full.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - sda_oe, rx_valid, rx_first, busy, ovf all 0; rx_data=0.
  - Synchronizer flops reset to 1 (bus idle high) so that no false START is seen on release.
- Sync and edge detection:
  - scl_s/sda_s are the last synchronizer stage; the previous samples are kept one extra cycle.
  - SCL rise/fall = edge of scl_s.
  - START = sda_s falls while scl_s=1. STOP = sda_s rises while scl_s=1.
  - Both are evaluated before bit sampling in the same cycle.
- Bit sampling: on SCL rise, MSB first, into an 8-bit shift register; a 3-bit counter tracks the bit index.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE: on START -> ADDR, busy=1, bit counter cleared.
  - ADDR: after the 8th SCL rise, check {addr[6:0], rw}.
    - Match with rw=0 -> ADDR_ACK.
    - Otherwise -> IGNORE; read requests are NACKed (this block is write-only).
  - ADDR_ACK: on the next SCL fall, sda_oe=1. On the following SCL fall, sda_oe=0 -> DATA with first_pending=1.
  - DATA: on the 8th SCL rise:
    - If the output buffer is free (rx_valid=0, or rx_valid & rx_ready in this cycle), in the next cycle load rx_data, set rx_valid=1, set rx_first=first_pending, clear first_pending, go to DATA_ACK.
    - Else drop the byte, pulse ovf for one cycle, go to IGNORE (NACK).
  - DATA_ACK: same sda_oe timing as ADDR_ACK -> DATA.
  - IGNORE: sda_oe=0; wait for START or STOP.
- Any state:
  - STOP -> IDLE, busy=0, sda_oe=0 in the next cycle. A partial byte is discarded with no rx_valid and no ovf.
  - START (repeated) -> ADDR, sda_oe=0, bit counter cleared. first_pending is set again on the next address ACK.
- Output handshake:
  - rx_valid stays high until rx_valid & rx_ready; it then clears in the next cycle unless a new byte loads in the same cycle.
  - rx_data and rx_first do not change while rx_valid=1 and rx_ready=0.
  - STOP and START do not clear a pending rx_valid.
- Latency: rx_valid rises 1 clk after the cycle in which the 8th synced SCL rise is detected. Total from the pad edge: SYNC_STAGES+2 clk.
- Bus protocol: sda_oe changes only in the cycle after an SCL fall (or on START/STOP/reset), never while scl_s=1.

Test Plan:
- Write 0x42(W) then 0xA5, 0x3C with rx_ready=1 -> ACK on all three bytes. rx_valid pulses carry 0xA5 with rx_first=1, then 0x3C with rx_first=0. busy=0 after STOP.
- Address 0x43(W) followed by 0x11 -> sda_oe never asserted, no rx_valid, state stays IGNORE until STOP.
- Address 0x42(R) -> NACK on the address, no rx_valid, ovf=0.
- rx_ready=0; write 0x42, 0x01, 0x02 -> 0x01 ACKed and held with rx_valid=1. 0x02 NACKed, ovf pulses exactly 1 clk. Raising rx_ready transfers 0x01 only.
- Repeated START mid-byte, then 0x42(W), 0x77 -> partial byte discarded, 0x77 delivered with rx_first=1.
- Assert rst_n=0 while sda_oe=1 during an ACK -> sda_oe=0 immediately (async). After release with the bus idle: no busy, no false START.
